// File: rtl/ahb_lite_master_arbiter.sv
// Two-master AHB-Lite arbiter: round-robin address-phase selection with burst locking,
// data-phase owner tracking, and HREADY-based stalling of the losing master.
module ahb_lite_master_arbiter #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic [1:0]            HTRANS_M0,
   input  logic [ADDR_WIDTH-1:0] HADDR_M0,
   input  logic                  HWRITE_M0,
   input  logic [2:0]            HSIZE_M0,
   input  logic [31:0]           HWDATA_M0,
   input  logic [1:0]            HTRANS_M1,
   input  logic [ADDR_WIDTH-1:0] HADDR_M1,
   input  logic                  HWRITE_M1,
   input  logic [2:0]            HSIZE_M1,
   input  logic [31:0]           HWDATA_M1,
   output logic                  HREADY_M0,
   output logic                  HREADY_M1,
   output logic                  HRESP_M0,
   output logic                  HRESP_M1,
   output logic [31:0]           HRDATA_M,
   output logic [1:0]            HTRANS,
   output logic [ADDR_WIDTH-1:0] HADDR,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [31:0]           HWDATA,
   input  logic                  HREADY,
   input  logic                  HRESP,
   input  logic [31:0]           HRDATA
);

   logic last_owner;
   logic data_owner;
   logic data_active;
   logic sel;

   logic req0, req1, cont0, cont1;

   assign req0  = (HTRANS_M0 == 2'b10);
   assign req1  = (HTRANS_M1 == 2'b10);
   assign cont0 = HTRANS_M0[0];
   assign cont1 = HTRANS_M1[0];

   // A burst in progress (SEQ/BUSY) keeps the bus; otherwise alternate on contention.
   always_comb begin
      sel = last_owner;
      if (last_owner ? cont1 : cont0)
         sel = last_owner;
      else if (req0 && req1)
         sel = ~last_owner;
      else if (req0)
         sel = 1'b0;
      else if (req1)
         sel = 1'b1;
   end

   always_comb begin
      if (sel) begin
         HTRANS = HTRANS_M1;
         HADDR  = HADDR_M1;
         HWRITE = HWRITE_M1;
         HSIZE  = HSIZE_M1;
      end else begin
         HTRANS = HTRANS_M0;
         HADDR  = HADDR_M0;
         HWRITE = HWRITE_M0;
         HSIZE  = HSIZE_M0;
      end
   end

   // Address phase -> data phase boundary; a slave wait state freezes ownership.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         last_owner  <= 1'b0;
         data_owner  <= 1'b0;
         data_active <= 1'b0;
      end else if (HREADY) begin
         data_owner  <= sel;
         data_active <= HTRANS[1];
         if (HTRANS[1])
            last_owner <= sel;
      end
   end

   assign HWDATA    = data_owner ? HWDATA_M1 : HWDATA_M0;
   assign HRDATA_M  = HRDATA;

   // A master that is neither on the address bus nor in its data phase is stalled only if it wants the bus.
   always_comb begin
      HREADY_M0 = HREADY;
      if (!(!sel || (data_active && !data_owner)) && (req0 || cont0))
         HREADY_M0 = 1'b0;
      HREADY_M1 = HREADY;
      if (!(sel || (data_active && data_owner)) && (req1 || cont1))
         HREADY_M1 = 1'b0;
   end

   assign HRESP_M0 = HRESP && data_active && !data_owner;
   assign HRESP_M1 = HRESP && data_active &&  data_owner;

endmodule
